// File: rtl/codeword_lut_pkg.sv
// Shared widths, table entry type and helpers for the multi-lane codeword LUT.
package codeword_lut_pkg;

  localparam int SYMBOL_WIDTH = 4;
  localparam int CODE_WIDTH   = 16;
  localparam int LEN_WIDTH    = 5;
  localparam int LANES        = 2;
  localparam int DEPTH        = 2 ** SYMBOL_WIDTH;
  localparam int MCNT_WIDTH   = 16;

  // Longest legal codeword, sized to compare directly against cfg_len.
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(CODE_WIDTH);

  typedef struct packed {
    logic                  valid;
    logic [LEN_WIDTH-1:0]  len;
    logic [CODE_WIDTH-1:0] code;
  } cw_entry_t;

  // Ones in the low len bits; len == CODE_WIDTH yields all ones, len == 0 yields zero.
  function automatic logic [CODE_WIDTH-1:0] len_mask(input logic [LEN_WIDTH-1:0] len);
    logic [CODE_WIDTH:0] one_hot;
    one_hot = (CODE_WIDTH + 1)'(1) << len;
    return one_hot[CODE_WIDTH-1:0] - CODE_WIDTH'(1);
  endfunction

  function automatic logic [MCNT_WIDTH-1:0] miss_popcount(input logic [LANES-1:0] miss);
    logic [MCNT_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + MCNT_WIDTH'(miss[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/codeword_lut_if.sv
// Config and stream bundle of the codeword LUT; master drives inputs, slave is the LUT.
interface codeword_lut_if;
  import codeword_lut_pkg::*;

  // Config: one write or clear per cycle, no handshake.
  logic                          cfg_en;
  logic                          cfg_clear;
  logic [SYMBOL_WIDTH-1:0]       cfg_symbol;
  logic [CODE_WIDTH-1:0]         cfg_code;
  logic [LEN_WIDTH-1:0]          cfg_len;
  logic                          cfg_err;

  // Stream: a beat moves on a cycle where valid && ready; a valid beat and its
  // payload are held unchanged by the sender until that cycle.
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES*SYMBOL_WIDTH-1:0] in_symbols;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*CODE_WIDTH-1:0]   out_codes;
  logic [LANES*LEN_WIDTH-1:0]    out_lens;
  logic [LANES-1:0]              out_miss;
  logic [MCNT_WIDTH-1:0]         miss_count;

  modport master (
    output cfg_en, cfg_clear, cfg_symbol, cfg_code, cfg_len,
    output in_valid, in_symbols, out_ready,
    input  cfg_err, in_ready, out_valid, out_codes, out_lens, out_miss, miss_count
  );

  modport slave (
    input  cfg_en, cfg_clear, cfg_symbol, cfg_code, cfg_len,
    input  in_valid, in_symbols, out_ready,
    output cfg_err, in_ready, out_valid, out_codes, out_lens, out_miss, miss_count
  );

endinterface

// File: rtl/codeword_lut_table.sv
// Symbol-indexed entry storage: one write port with bulk invalidate, LANES async read ports.
module codeword_lut_table
  import codeword_lut_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic [SYMBOL_WIDTH-1:0]       wr_symbol,
  input  cw_entry_t                     wr_entry,
  input  logic [LANES*SYMBOL_WIDTH-1:0] rd_symbols,
  output cw_entry_t [LANES-1:0]         rd_entries
);

  cw_entry_t mem [DEPTH];

  // Clear only drops valid bits; stale code/len are unreachable until rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].valid <= 1'b0;
      end
    end else if (wr_en) begin
      mem[wr_symbol] <= wr_entry;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rd_entries[l] = mem[rd_symbols[l*SYMBOL_WIDTH +: SYMBOL_WIDTH]];
    end
  end

endmodule

// File: rtl/codeword_lut.sv
// Multi-lane symbol-to-codeword LUT with one-cycle lookup and a registered output stage.
// Optional saturating miss counter enabled by CODEWORD_LUT_MISS_CNT_EN.
module codeword_lut
  import codeword_lut_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  codeword_lut_if.slave bus
);

  logic                        cfg_len_bad;
  logic                        tbl_wr;
  cw_entry_t                   wr_entry;
  cw_entry_t [LANES-1:0]       rd_entries;

  logic                        in_ready_int;
  logic                        accept;
  logic                        transfer;

  logic                        out_valid_q;
  logic [LANES*CODE_WIDTH-1:0] out_codes_q;
  logic [LANES*LEN_WIDTH-1:0]  out_lens_q;
  logic [LANES-1:0]            out_miss_q;
  logic [LANES*CODE_WIDTH-1:0] nxt_codes;
  logic [LANES*LEN_WIDTH-1:0]  nxt_lens;
  logic [LANES-1:0]            nxt_miss;
  logic                        cfg_err_q;

  // Codes are masked on the way in so every stored entry is already clean.
  assign cfg_len_bad = bus.cfg_len > MAX_LEN;
  assign tbl_wr      = bus.cfg_en && !bus.cfg_clear && !cfg_len_bad;
  assign wr_entry    = '{valid: 1'b1,
                         len:   bus.cfg_len,
                         code:  bus.cfg_code & len_mask(bus.cfg_len)};

  codeword_lut_table u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (bus.cfg_clear),
    .wr_en      (tbl_wr),
    .wr_symbol  (bus.cfg_symbol),
    .wr_entry   (wr_entry),
    .rd_symbols (bus.in_symbols),
    .rd_entries (rd_entries)
  );

  // Lookups never share a cycle with a table change, so reads see a stable table.
  assign in_ready_int = !bus.cfg_en && !bus.cfg_clear && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && in_ready_int;
  assign transfer     = out_valid_q && bus.out_ready;

  always_comb begin
    nxt_codes = '0;
    nxt_lens  = '0;
    nxt_miss  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (rd_entries[l].valid) begin
        nxt_codes[l*CODE_WIDTH +: CODE_WIDTH] = rd_entries[l].code;
        nxt_lens[l*LEN_WIDTH +: LEN_WIDTH]    = rd_entries[l].len;
      end else begin
        nxt_miss[l] = 1'b1;
      end
    end
  end

  // Payload only loads on accept, which gives the stall hold for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_codes_q <= '0;
      out_lens_q  <= '0;
      out_miss_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_codes_q <= nxt_codes;
      out_lens_q  <= nxt_lens;
      out_miss_q  <= nxt_miss;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else if (bus.cfg_en && !bus.cfg_clear && cfg_len_bad) begin
      cfg_err_q <= 1'b1;
    end
  end

`ifdef CODEWORD_LUT_MISS_CNT_EN
  logic [MCNT_WIDTH-1:0] miss_cnt_q;
  logic [MCNT_WIDTH:0]   miss_sum;

  assign miss_sum = {1'b0, miss_cnt_q} + {1'b0, miss_popcount(out_miss_q)};

  // A clear wins over a same-cycle transfer; the carry bit flags saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q <= '0;
    end else if (bus.cfg_clear) begin
      miss_cnt_q <= '0;
    end else if (transfer) begin
      miss_cnt_q <= miss_sum[MCNT_WIDTH] ? '1 : miss_sum[MCNT_WIDTH-1:0];
    end
  end

  assign bus.miss_count = miss_cnt_q;
`else
  logic unused_transfer;
  assign unused_transfer = transfer;
  assign bus.miss_count  = '0;
`endif

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.out_codes = out_codes_q;
  assign bus.out_lens  = out_lens_q;
  assign bus.out_miss  = out_miss_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_codeword_lut.sv
// Scoreboard bench for codeword_lut: driver pushes expected beats, monitor pops on transfer.
module tb_codeword_lut;
  import codeword_lut_pkg::*;

  localparam int EW = LANES + LANES*LEN_WIDTH + LANES*CODE_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  codeword_lut_if bus();

  codeword_lut dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  logic                  mdl_valid [DEPTH];
  logic [LEN_WIDTH-1:0]  mdl_len   [DEPTH];
  logic [CODE_WIDTH-1:0] mdl_code  [DEPTH];
  logic [15:0]           exp_mcnt;
  logic                  rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] model_beat(input logic [LANES*SYMBOL_WIDTH-1:0] syms);
    logic [LANES-1:0]            m;
    logic [LANES*LEN_WIDTH-1:0]  l;
    logic [LANES*CODE_WIDTH-1:0] c;
    int s;
    m = '0; l = '0; c = '0;
    for (int i = 0; i < LANES; i++) begin
      s = int'(syms[i*SYMBOL_WIDTH +: SYMBOL_WIDTH]);
      if (mdl_valid[s]) begin
        l[i*LEN_WIDTH +: LEN_WIDTH]   = mdl_len[s];
        c[i*CODE_WIDTH +: CODE_WIDTH] = mdl_code[s];
      end else begin
        m[i] = 1'b1;
      end
    end
    return {m, l, c};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl_valid[i] = 1'b0;
  endtask

  task automatic cfg_write(input int s, input logic [15:0] code, input int len);
    bus.cfg_en     = 1'b1;
    bus.cfg_symbol = SYMBOL_WIDTH'(s);
    bus.cfg_code   = code;
    bus.cfg_len    = LEN_WIDTH'(len);
    @(posedge clk); #1;
    bus.cfg_en = 1'b0;
    if (len <= CODE_WIDTH) begin
      mdl_valid[s] = 1'b1;
      mdl_len[s]   = LEN_WIDTH'(len);
      mdl_code[s]  = code & 16'((32'd1 << len) - 1);
    end
  endtask

  task automatic cfg_clear_pulse();
    bus.cfg_clear = 1'b1;
    @(posedge clk); #1;
    bus.cfg_clear = 1'b0;
    model_clear();
    exp_mcnt = '0;
  endtask

  // Leaves in_valid high so back-to-back calls stream at full rate.
  task automatic send_beat(input logic [LANES*SYMBOL_WIDTH-1:0] syms, input logic [EW-1:0] exp);
    int  n = 0;
    bit  done = 0;
    bus.in_valid   = 1'b1;
    bus.in_symbols = syms;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(exp);
        done = 1;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        check("accept_timeout", 64'd0, 64'd1);
        done = 1;
      end
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_mcnt();
`ifdef CODEWORD_LUT_MISS_CNT_EN
    check("miss_count", bus.miss_count, exp_mcnt);
`else
    check("miss_count", bus.miss_count, 64'd0);
`endif
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      else            bus.out_ready = 1'b1;
    end
  end

  initial begin : monitor
    logic [EW-1:0] act, held, e;
    logic prev_stall;
    int t;
    prev_stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      act = {bus.out_miss, bus.out_lens, bus.out_codes};
      if (bus.out_valid && !bus.out_ready) begin
        check("in_ready_stall", bus.in_ready, 64'd0);
        if (prev_stall) check("hold", act, held);
        held = act;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", act, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("beat", act, e);
          t = int'(exp_mcnt) + $countones(e[EW-1 -: LANES]);
          exp_mcnt = (t > 65535) ? 16'hFFFF : 16'(t);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [LANES*SYMBOL_WIDTH-1:0] syms;
    bus.cfg_en = 1'b0; bus.cfg_clear = 1'b0; bus.cfg_symbol = '0;
    bus.cfg_code = '0; bus.cfg_len = '0;
    bus.in_valid = 1'b0; bus.in_symbols = '0;
    model_clear();
    exp_mcnt = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 64'd0);
    check("rst_out_codes", bus.out_codes, 64'd0);
    check("rst_out_lens",  bus.out_lens,  64'd0);
    check("rst_out_miss",  bus.out_miss,  64'd0);
    check("rst_cfg_err",   bus.cfg_err,   64'd0);
    check("rst_miss_count", bus.miss_count, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty table: both lanes miss.
    send_beat({4'd5, 4'd3}, {2'b11, 10'd0, 32'd0});
    idle(); drain();
`ifdef CODEWORD_LUT_MISS_CNT_EN
    check("miss_count_first", bus.miss_count, 64'd2);
`else
    check("miss_count_first", bus.miss_count, 64'd0);
`endif

    // Masking: sym5 code FFFF len 4 reads back as 000F. Lane0=5, lane1=3.
    cfg_write(3, 16'h0005, 3);
    cfg_write(5, 16'hFFFF, 4);
    send_beat({4'd3, 4'd5}, {2'b00, 5'd3, 5'd4, 16'h0005, 16'h000F});
    idle(); drain();

    // Over-long write is dropped and flags a sticky error.
    cfg_write(3, 16'h1234, 17);
    check("cfg_err_set", bus.cfg_err, 64'd1);
    send_beat({4'd3, 4'd3}, {2'b00, 5'd3, 5'd3, 16'h0005, 16'h0005});
    // Zero-length is a hit; full-length keeps every bit.
    cfg_write(9, 16'hABCD, 0);
    cfg_write(10, 16'hBEEF, 16);
    send_beat({4'd9, 4'd9}, {2'b00, 10'd0, 32'd0});
    send_beat({4'd9, 4'd10}, {2'b00, 5'd0, 5'd16, 16'h0000, 16'hBEEF});
    idle(); drain();
    cfg_clear_pulse();
    check("cfg_err_sticky", bus.cfg_err, 64'd1);
    send_beat({4'd5, 4'd3}, {2'b11, 10'd0, 32'd0});
    idle(); drain();
    check_mcnt();

    // Random backpressure over 20 streamed beats.
    for (int s = 0; s < DEPTH; s++) begin
      if (s % 5 != 4) cfg_write(s, 16'hA5C3 ^ 16'(s * 16'h1111), s + 1);
    end
    rand_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      syms = {4'((2*k + 1) % 16), 4'((2*k) % 16)};
      send_beat(syms, model_beat(syms));
    end
    idle();
    rand_ready = 1'b0;
    drain();
    check_mcnt();

    // Simultaneous write and clear while a beat waits: clear wins, nothing accepted.
    bus.in_valid = 1'b1; bus.in_symbols = {4'd7, 4'd0};
    bus.cfg_en = 1'b1; bus.cfg_clear = 1'b1;
    bus.cfg_symbol = 4'd7; bus.cfg_code = 16'h0001; bus.cfg_len = 5'd1;
    @(negedge clk);
    check("in_ready_cfg", bus.in_ready, 64'd0);
    @(posedge clk); #1;
    bus.cfg_en = 1'b0; bus.cfg_clear = 1'b0;
    model_clear();
    exp_mcnt = '0;
    send_beat({4'd7, 4'd0}, {2'b11, 10'd0, 32'd0});
    idle(); drain();
    check_mcnt();

    // Reset mid-stream while out_valid is high.
    cfg_write(2, 16'h0003, 2);
    send_beat({4'd2, 4'd2}, {2'b00, 5'd2, 5'd2, 16'h0003, 16'h0003});
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", bus.out_valid, 64'd0);
    check("rst_async_cfg_err", bus.cfg_err, 64'd0);
    exp_q.delete();
    model_clear();
    exp_mcnt = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat({4'd2, 4'd2}, {2'b11, 10'd0, 32'd0});
    idle(); drain();
    check_mcnt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/codeword_lut.md
Name: codeword_lut

Overview:
Multi-lane symbol-to-codeword lookup table for the entropy encoder datapath. It is the generalised successor of the single-lane symbol LUT. Software loads {code, length} pairs per symbol through a config port. The stream side then looks up LANES symbols per beat under valid/ready handshakes and produces codes, lengths and per-lane miss flags for the bit packer.

Parameters:
SYMBOL_WIDTH, 4, bits per symbol; table depth = 2**SYMBOL_WIDTH
CODE_WIDTH, 16, max codeword bits
LEN_WIDTH, 5, bits of length field; must satisfy 2**LEN_WIDTH > CODE_WIDTH
LANES, 2, symbols looked up per beat

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
cfg_en  input  1  write table entry this cycle
cfg_clear  input  1  invalidate all entries this cycle
cfg_symbol  input  SYMBOL_WIDTH  entry index
cfg_code  input  CODE_WIDTH  codeword, right-aligned
cfg_len  input  LEN_WIDTH  codeword length
cfg_err  output  1  sticky: a write had cfg_len > CODE_WIDTH
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
in_symbols  input  LANES*SYMBOL_WIDTH  lane i at bits [i*SYMBOL_WIDTH +: SYMBOL_WIDTH]
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts
out_codes  output  LANES*CODE_WIDTH  per-lane codeword, bits above len forced 0
out_lens  output  LANES*LEN_WIDTH  per-lane length
out_miss  output  LANES  lane symbol had no valid entry
miss_count  output  16  miss counter (see Optional Feature)

Behaviour:
- Storage: 2**SYMBOL_WIDTH entries of {valid, len, code}.
- Reset (async): all entries invalid with code=0 and len=0; out_valid=0; out_codes, out_lens, out_miss, cfg_err and miss_count all 0.
- Config write (cfg_en=1, cfg_clear=0): entry[cfg_symbol] <= {1, cfg_len, cfg_code masked to its low cfg_len bits}. Visible to lookups accepted from the next cycle onward.
- cfg_len > CODE_WIDTH: the write is dropped and cfg_err is set. cfg_err clears only on reset.
- cfg_len = 0 is a legal write. It produces a valid entry with len 0, which is not a miss.
- cfg_clear=1 clears all valid bits in one cycle and takes priority over a simultaneous cfg_en. cfg_err is unaffected.
- in_ready = !cfg_en && !cfg_clear && (!out_valid || out_ready). No lookup is ever accepted in a cycle that modifies the table.
- Lookup latency: 1 cycle. A beat accepted at edge N appears with out_valid=1 after edge N.
- Full throughput: one beat per cycle while out_ready=1.
- Per lane: on hit, out_code = entry.code, out_len = entry.len, out_miss = 0. On invalid entry, code = 0, len = 0, out_miss = 1.
- Lanes are independent. Identical symbols in several lanes are legal.
- Hold: while out_valid && !out_ready, all outputs stay stable.
- out_valid drops after out_ready when no new beat is accepted.
- Config during a stalled output does not alter the held output.

Optional Feature:
Macro CODEWORD_LUT_MISS_CNT_EN.
- Defined: miss_count increments by popcount(out_miss) of each beat, counted once when the beat is transferred (out_valid && out_ready). It saturates at 16'hFFFF, clears on reset and on cfg_clear, and a clear beats a same-cycle increment.
- Undefined: miss_count is tied to 0 and no counter logic is built.

Decomposition:
- Package codeword_lut_pkg holds:
  - the typedef cw_entry_t packed struct {valid, len, code}, parameterised via package localparams with the same defaults;
  - the localparam DEPTH = 2**SYMBOL_WIDTH.
- Sub-module codeword_lut_table holds the storage array:
  - one write port with clear;
  - LANES combinational read ports;
  - it is instantiated once in codeword_lut.
- The top level owns the handshake, output register, masking, error flag and counter.

Test Plan:
- Reset, then a lookup of lanes {3,5} with an empty table -> next cycle out_miss=2'b11, codes=0, lens=0. With the macro defined, miss_count=2 after the transfer.
- Write sym3={code 16'h0005, len 3} and sym5={16'hFFFF, len 4}, then look up {5,3} -> out_codes={16'h0005, 16'h000F}, out_lens={3,4}, out_miss=0.
- Write with cfg_len=17 (CODE_WIDTH=16) -> entry unchanged, cfg_err=1 and stays 1 through a following cfg_clear.
- Hold in_valid=1 and toggle out_ready randomly over 20 beats of incrementing symbols -> no beat dropped or duplicated, outputs stable during stalls, in_ready=0 whenever out_valid && !out_ready.
- Assert cfg_en and cfg_clear together while in_valid=1 -> in_ready=0, all entries invalid afterward, the next lookup shows all misses.
- Assert rst_n low mid-stream with out_valid=1 -> out_valid=0 immediately, the table is invalidated, and the first post-reset lookup misses.
